hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_W, default 5, meaning register-specifier width.
REQ-002 The block SHALL have parameter BR_PENALTY, default 3, legal 1..15, meaning total flush cycles per branch.
REQ-003 The block SHALL have parameter INIT_CYCLES, default 1, legal 1..15, meaning cycles of forced fetch after reset.
REQ-004 The block SHALL have parameter ZERO_REG_EN, default 1, meaning that a register-0 match never stalls when set to 1.
REQ-005 Port: clk  in  1  sole clock, all state on rising edge.
REQ-006 Port: rst  in  1  reset, asynchronous, active-high.
REQ-007 Port: ie_mem_read  in  1  load instruction in IE stage.
REQ-008 Port: ie_rt  in  REG_W  load destination in IE.
REQ-009 Port: ii_rs, ii_rt  in  REG_W each  source specifiers in II.
REQ-010 Port: ii_use_rs, ii_use_rt  in  1 each  II instruction reads rs/rt.
REQ-011 Port: ii_branch  in  1  branch decoded in II.
REQ-012 Port: ext_stall  in  1  external (memory) hold request.
REQ-013 Port: pc_write, ii_write  out  1 each  PC / II-register write enables.
REQ-014 Port: ctrl0  out  1  zero all control signals into IE (bubble).
REQ-015 Port: flush  out  1  squash wrong-path instructions.
REQ-016 Port: hz_state  out  2  current FSM state encoding.
REQ-017 Port: stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-018 hazard SHALL equal ie_mem_read AND ((ii_use_rs AND ie_rt==ii_rs) OR (ii_use_rt AND ie_rt==ii_rt)) AND NOT (ZERO_REG_EN AND ie_rt==0); combinational, same-cycle.
REQ-019 The FSM SHALL have states INIT=0, RUN=1, FLUSH=2; encoding 3 is unused and SHALL recover to RUN on the next edge.
REQ-020 INIT: outputs pc_write=1, ii_write=1, ctrl0=0, flush=0; hazard, ii_branch, and ext_stall are ignored; transition to RUN after exactly INIT_CYCLES cycles.
REQ-021 RUN, priority ext_stall > hazard > ii_branch > idle, with outputs (pc_write, ii_write, ctrl0, flush) combinational in the current cycle.
REQ-022 RUN + ext_stall: outputs 0,0,0,0; state unchanged.
REQ-023 RUN + hazard (no ext_stall): outputs 0,0,1,0; stall_cnt increments; state unchanged. A branch in II is held and re-evaluated in the next cycle.
REQ-024 RUN + ii_branch (no ext_stall, no hazard): outputs 1,1,0,1; if BR_PENALTY>1, go to FLUSH with the remaining-flush counter = BR_PENALTY-1; else stay in RUN.
REQ-025 RUN idle: outputs 1,1,0,0.
REQ-026 FLUSH: flush=1, ctrl0=0, and hazard and ii_branch are ignored (wrong path).
- Without ext_stall: pc_write=1, ii_write=1; counter decrements; go to RUN on the edge where the counter equals 1.
- With ext_stall: pc_write=0, ii_write=0; counter frozen; flush stays 1.
REQ-027 Consequently flush SHALL be high for exactly BR_PENALTY non-stalled cycles per accepted branch.
REQ-028 stall_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-029 Comparisons SHALL be full REG_W bits, unsigned.

Reset
REQ-030 rst high SHALL force asynchronously: state=INIT, init counter=0, flush counter=0, stall_cnt=0.
REQ-031 While rst is high, outputs SHALL be pc_write=1, ii_write=1, ctrl0=0, flush=0, hz_state=0.
REQ-032 Reset asserted mid-FLUSH or mid-stall SHALL abandon the operation with no residual flush after release.

Structure
REQ-033 Package hazard_pkg SHALL hold the state encodings (INIT/RUN/FLUSH), the stall_cnt width of 16, and the saturation constant.
REQ-034 One sub-module reg_match (REG_W-bit equality comparator) SHALL be instantiated twice (rs and rt).

Verification
REQ-035 Reset, INIT_CYCLES=2: pc_write=1 for 2 cycles despite a live hazard, hz_state goes 0->0->1, stall_cnt=0.
REQ-036 RUN, ie_mem_read=1, ie_rt=7, ii_rs=7, ii_use_rs=1: same cycle pc_write=0, ii_write=0, ctrl0=1; stall_cnt goes 0->1. Repeat with ie_rt=0, ii_rs=0: no stall.
REQ-037 BR_PENALTY=3, ii_branch pulse: flush=1 for exactly 3 cycles, hz_state 1->2->2->1; a ii_branch during FLUSH adds no extra cycles.
REQ-038 Same-cycle hazard and ii_branch: stall first (ctrl0=1, flush=0), then branch accepted next cycle, flush 3 cycles.
REQ-039 FLUSH with ext_stall=1 for 2 cycles mid-window: pc_write=0, flush held, total flush cycles = 3 + 2.
REQ-040 rst pulsed during FLUSH: flush=0 immediately; after release, INIT then RUN with no flush; force stall_cnt near 16'hFFFF and confirm saturation.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// stall-counter width and its saturation value.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    localparam int                     STALL_CNT_W   = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

endpackage : hazard_pkg

// File: rtl/reg_match.sv
// Full-width unsigned equality comparator for register specifiers.
module reg_match #(
    parameter int W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         match_o
);

    assign match_o = (a_i == b_i);

endmodule : reg_match

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: detects load-use hazards between the IE and II
// stages, inserts bubbles, and sequences the branch flush window. The control
// outputs are combinational in the current cycle so the pipeline can react in
// the same cycle the hazard appears.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int BR_PENALTY  = 3,
    parameter int INIT_CYCLES = 1,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ie_mem_read,
    input  logic [REG_W-1:0]       ie_rt,
    input  logic [REG_W-1:0]       ii_rs,
    input  logic [REG_W-1:0]       ii_rt,
    input  logic                   ii_use_rs,
    input  logic                   ii_use_rt,
    input  logic                   ii_branch,
    input  logic                   ext_stall,
    output logic                   pc_write,
    output logic                   ii_write,
    output logic                   ctrl0,
    output logic                   flush,
    output logic [1:0]             hz_state,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    // Last value of the init counter before leaving INIT, and the number of
    // flush cycles still owed once the branch cycle itself has flushed.
    localparam logic [3:0] INIT_LAST  = 4'(INIT_CYCLES - 1);
    localparam logic [3:0] FLUSH_LOAD = 4'(BR_PENALTY - 1);

    hz_state_e              state_q, state_d;
    logic [3:0]             init_cnt_q, init_cnt_d;
    logic [3:0]             flush_cnt_q, flush_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic                   stall_inc_s;

    logic rs_match_s;
    logic rt_match_s;
    logic zero_blk_s;
    logic hazard_s;

    reg_match #(.W(REG_W)) u_match_rs (
        .a_i     (ie_rt),
        .b_i     (ii_rs),
        .match_o (rs_match_s)
    );

    reg_match #(.W(REG_W)) u_match_rt (
        .a_i     (ie_rt),
        .b_i     (ii_rt),
        .match_o (rt_match_s)
    );

    // A load into register 0 never produces a real dependency when enabled.
    assign zero_blk_s = (ZERO_REG_EN != 0) && (ie_rt == {REG_W{1'b0}});

    assign hazard_s = ie_mem_read
                    & ((ii_use_rs & rs_match_s) | (ii_use_rt & rt_match_s))
                    & ~zero_blk_s;

    assign hz_state  = state_q;
    assign stall_cnt = stall_cnt_q;

    // State, init-counter and flush-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= 4'd0;
            flush_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Saturating count of load-use stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= {STALL_CNT_W{1'b0}};
        end else if (stall_inc_s && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    // Next-state and output decode; priority in RUN is ext_stall > hazard > branch.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall_inc_s = 1'b0;
        pc_write    = 1'b1;
        ii_write    = 1'b1;
        ctrl0       = 1'b0;
        flush       = 1'b0;

        case (state_q)
            ST_INIT: begin
                // Forced fetch; hazards, branches and external holds are ignored.
                if (init_cnt_q >= INIT_LAST) begin
                    state_d    = ST_RUN;
                    init_cnt_d = 4'd0;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end

            ST_RUN: begin
                if (ext_stall) begin
                    pc_write = 1'b0;
                    ii_write = 1'b0;
                end else if (hazard_s) begin
                    // Bubble into IE; any branch in II is held and retried.
                    pc_write    = 1'b0;
                    ii_write    = 1'b0;
                    ctrl0       = 1'b1;
                    stall_inc_s = 1'b1;
                end else if (ii_branch) begin
                    // The branch cycle itself is the first flush cycle.
                    flush = 1'b1;
                    if (BR_PENALTY > 1) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_FLUSH: begin
                // Wrong-path window: hazard and branch inputs are meaningless here.
                flush = 1'b1;
                if (ext_stall) begin
                    pc_write = 1'b0;
                    ii_write = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                    if (flush_cnt_q <= 4'd1) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = 4'd0;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end

            default: begin
                // Unused encoding: hold the pipeline for one cycle and resume.
                state_d     = ST_RUN;
                flush_cnt_d = 4'd0;
                init_cnt_d  = 4'd0;
                pc_write    = 1'b0;
                ii_write    = 1'b0;
                ctrl0       = 1'b1;
            end
        endcase
    end

endmodule : hazard_ctrl
